// File: rtl/dec_scan_ctrl_pkg.sv
// rtl/dec_scan_ctrl_pkg.sv - shared state encoding, slot count and slot helper for the decoder scan sequencer
package dec_scan_ctrl_pkg;

  localparam int NSLOT = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BLANK = ST_BLANK,
    DWELL = ST_DWELL
  } state_t;

  // True when no enabled slot lies above s, i.e. leaving s wraps the frame.
  function automatic logic is_top_slot(input logic [1:0] s, input logic [NSLOT-1:0] m);
    logic r;
    r = 1'b1;
    for (int k = 0; k < NSLOT; k++) begin
      if (k > int'(s) && m[k]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_next_slot.sv
// rtl/dec_next_slot.sv - rotate-priority search for the next enabled slot after cur
module dec_next_slot
  import dec_scan_ctrl_pkg::*;
(
  input  logic [1:0]       cur,
  input  logic [NSLOT-1:0] mask,
  output logic [1:0]       nxt,
  output logic             wrap,
  output logic             none
);

  logic       found;
  logic [1:0] idx;

  // Scanning cur+1 .. cur+4 modulo 4 yields the lowest index above cur, else the lowest overall.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int k = 1; k <= NSLOT; k++) begin
      idx = cur + 2'(k);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    none = ~found;
    wrap = found && (nxt <= cur);
  end

endmodule

// File: rtl/dec_scan_ctrl.sv
// rtl/dec_scan_ctrl.sv - scan sequencer driving en/i0/i1 of a 2-to-4 decoder with blanking and dwell
module dec_scan_ctrl
  import dec_scan_ctrl_pkg::*;
#(
  parameter int DWELL_CYC = 8,
  parameter int BLANK_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [NSLOT-1:0] mask,
  output logic             en,
  output logic             i0,
  output logic             i1,
  output logic             slot_start,
  output logic             frame_done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LD  = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
  localparam logic             DWELL_ONE = (DWELL_CYC == 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       code;
  logic [1:0]       search_cur;
  logic [1:0]       nxt;
  logic             wrap;
  logic             none;

  // In IDLE the search starts from the top slot so it returns the lowest enabled index.
  assign search_cur = (state == IDLE) ? 2'(NSLOT - 1) : code;

  dec_next_slot u_next (
    .cur  (search_cur),
    .mask (mask),
    .nxt  (nxt),
    .wrap (wrap),
    .none (none)
  );

  assign i0 = code[1];
  assign i1 = code[0];

  // frame_done is registered, so it is decided on the edge entering the final dwell cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      code       <= 2'd0;
      en         <= 1'b0;
      slot_start <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      slot_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run && !none) begin
            code <= nxt;
            busy <= 1'b1;
            if (BLANK_CYC > 0) begin
              state <= BLANK;
              cnt   <= BLANK_LD;
            end else begin
              state      <= DWELL;
              cnt        <= DWELL_LD;
              en         <= 1'b1;
              slot_start <= 1'b1;
              frame_done <= DWELL_ONE && is_top_slot(nxt, mask);
            end
          end
        end
        BLANK: begin
          if (cnt == '0) begin
            state      <= DWELL;
            cnt        <= DWELL_LD;
            en         <= 1'b1;
            slot_start <= 1'b1;
            frame_done <= DWELL_ONE && run && !none && wrap;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DWELL: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) frame_done <= run && !none && wrap;
          end else if (!run || none) begin
            state <= IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
          end else begin
            code <= nxt;
            if (BLANK_CYC > 0) begin
              state <= BLANK;
              cnt   <= BLANK_LD;
              en    <= 1'b0;
            end else begin
              cnt        <= DWELL_LD;
              slot_start <= 1'b1;
              frame_done <= DWELL_ONE && is_top_slot(nxt, mask);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// tb/tb_dec_scan_ctrl.sv - scoreboard bench for dec_scan_ctrl with slot-period reference model
module tb_dec_scan_ctrl;

  localparam int DA = 4;
  localparam int BA = 2;
  localparam int DB = 3;
  localparam int BB = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_a, run_b;
  logic [3:0] mask_a, mask_b;
  logic       en_a, i0_a, i1_a, ss_a, fd_a, busy_a;
  logic       en_b, i0_b, i1_b, ss_b, fd_b, busy_b;

  always #5 clk = ~clk;

  dec_scan_ctrl #(.DWELL_CYC(DA), .BLANK_CYC(BA), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .run(run_a), .mask(mask_a),
    .en(en_a), .i0(i0_a), .i1(i1_a),
    .slot_start(ss_a), .frame_done(fd_a), .busy(busy_a)
  );

  dec_scan_ctrl #(.DWELL_CYC(DB), .BLANK_CYC(BB), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .run(run_b), .mask(mask_b),
    .en(en_b), .i0(i0_b), .i1(i1_b),
    .slot_start(ss_b), .frame_done(fd_b), .busy(busy_b)
  );

  // Model: active flag, current slot and position within its blank+dwell period.
  typedef struct packed {
    logic       act;
    logic [1:0] slot;
    logic [7:0] pos;
    logic       fd;
  } ms_t;

  logic [5:0] exp_a[$];
  logic [5:0] exp_b[$];
  int         total = 0;
  int         bad = 0;
  int         timeouts = 0;
  int         cyc = 0;
  logic       started = 1'b0;
  logic       done_req = 1'b0;
  logic       summary_ready = 1'b0;
  ms_t        ma, mb;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    for (int c = 0; c < 4; c++) if (m[c]) return 2'(c);
    return 2'd0;
  endfunction

  function automatic logic [1:0] next_after(input logic [1:0] s, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(int'(s) + k) % 4]) return 2'((int'(s) + k) % 4);
    return s;
  endfunction

  function automatic logic is_last(input logic [1:0] s, input logic [3:0] m);
    for (int c = int'(s) + 1; c < 4; c++) if (m[c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic ms_t step(input ms_t s, input logic r, input logic rn,
                               input logic [3:0] m, input int b, input int d);
    ms_t n;
    n = s;
    if (r) begin
      n = '0;
    end else if (!s.act || int'(s.pos) == b + d - 1) begin
      if (rn && m != 4'd0) begin
        n.slot = s.act ? next_after(s.slot, m) : lowest(m);
        n.act  = 1'b1;
        n.pos  = 8'd0;
      end else begin
        n.act = 1'b0;
      end
    end else begin
      n.pos = s.pos + 8'd1;
    end
    if (!r && n.act && int'(n.pos) == b + d - 1)
      n.fd = rn && (m != 4'd0) && is_last(n.slot, m);
    return n;
  endfunction

  // Packed as {en, i0, i1, slot_start, frame_done, busy}.
  function automatic logic [5:0] expect_of(input ms_t s, input int b, input int d);
    logic e, st, f;
    e  = s.act && int'(s.pos) >= b;
    st = s.act && int'(s.pos) == b;
    f  = s.act && s.fd && int'(s.pos) == b + d - 1;
    return {e, s.slot, st, f, s.act};
  endfunction

  initial begin
    ma = '0;
    mb = '0;
    forever begin
      @(posedge clk);
      if (rst) started = 1'b1;
      if (started) begin
        ma = step(ma, rst, run_a, mask_a, BA, DA);
        mb = step(mb, rst, run_b, mask_b, BB, DB);
        exp_a.push_back(expect_of(ma, BA, DA));
        exp_b.push_back(expect_of(mb, BB, DB));
      end
    end
  end

  initial begin
    logic [5:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        a = {en_a, i0_a, i1_a, ss_a, fd_a, busy_a};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL dut_a cyc=%0d act=%b exp=%b (en,i0,i1,ss,fd,busy)", cyc, a, e);
        end
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        a = {en_b, i0_b, i1_b, ss_b, fd_b, busy_b};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL dut_b cyc=%0d act=%b exp=%b (en,i0,i1,ss,fd,busy)", cyc, a, e);
        end
      end
      if (done_req && !summary_ready) begin
        total++;
        if (timeouts != 0) begin
          bad++;
          $display("FAIL wait_timeout act=%0d exp=0", timeouts);
        end
        total++;
        if (exp_a.size() + exp_b.size() != 0) begin
          bad++;
          $display("FAIL queue_drain act=%0d exp=0", exp_a.size() + exp_b.size());
        end
        summary_ready = 1'b1;
      end
      cyc++;
    end
  end

  task automatic wait_start_a(input logic [1:0] want);
    int k;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (ss_a === 1'b1 && {i0_a, i1_a} === want) break;
      k++;
    end
    if (k >= 40) timeouts++;
  endtask

  initial begin
    rst    = 1'b1;
    run_a  = 1'b1;
    mask_a = 4'b1111;
    run_b  = 1'b1;
    mask_b = 4'b0001;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);

    mask_a = 4'b1010;
    repeat (30) @(negedge clk);
    wait_start_a(2'b01);
    mask_a = 4'b0100;
    repeat (24) @(negedge clk);

    mask_a = 4'b1111;
    wait_start_a(2'b10);
    @(negedge clk);
    run_a = 1'b0;
    repeat (12) @(negedge clk);

    run_a = 1'b1;
    wait_start_a(2'b11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Inputs only move in IDLE or on the first dwell cycle, well ahead of the decision point.
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      if ((ss_a || !busy_a) && $urandom_range(0, 3) == 0) begin
        run_a  = ($urandom_range(0, 7) != 0);
        mask_a = 4'($urandom_range(0, 15));
      end
      if ((ss_b || !busy_b) && $urandom_range(0, 3) == 0) begin
        run_b  = ($urandom_range(0, 7) != 0);
        mask_b = 4'($urandom_range(0, 15));
      end
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    done_req = 1'b1;
    for (int k = 0; k < 10 && !summary_ready; k++) @(negedge clk);
    if (!summary_ready) $display("FAIL summary_wait act=0 exp=1");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
